// File: rtl/data_ram_responder.sv
// Responder for MEM-stage data accesses: one outstanding load/store on an internal
// word-addressed RAM, completed after WAIT_STATES extra cycles and acknowledged with a pulse.
module data_ram_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [31:2] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] word_idx;
    logic              in_range;
    logic              access;
    logic              mem_we;
    logic              unused_addr_bits;

    // Lane choice comes only from sel_i, so the byte offset is never consumed.
    assign unused_addr_bits = ^addr_i[1:0];

    assign word_idx = req_addr[ADDR_W+1:2];
    assign in_range = (req_addr[31:ADDR_W+2] == '0);
    assign access   = (state == ST_WAIT) && (cnt == 4'd0);
    assign mem_we   = !rst && access && req_we && in_range;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        stallreq_o = 1'b0;
        case (state)
            ST_IDLE: stallreq_o = ce_i;
            ST_WAIT: stallreq_o = 1'b1;
            default: stallreq_o = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rdata_o <= 32'd0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack_o <= 1'b0;
                    err_o <= 1'b0;
                    if (ce_i) begin
                        cnt   <= 4'(WAIT_STATES);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!in_range)
                            rdata_o <= 32'd0;
                        else if (!req_we)
                            rdata_o <= mem[word_idx];
                        ack_o <= 1'b1;
                        err_o <= !in_range;
                        state <= ST_ACK;
                    end
                end
                default: begin
                    // The request is still presented during ACK; it is not taken again.
                    ack_o <= 1'b0;
                    err_o <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && ce_i) begin
            req_we    <= we_i;
            req_sel   <= sel_i;
            req_addr  <= addr_i[31:2];
            req_wdata <= wdata_i;
        end
    end

    // NOTE: the RAM array has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b])
                    mem[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: a transaction-level model predicts stall/ack/err/rdata every
// cycle for two instances (WAIT_STATES=2 and 0); directed requests add literal checks.
module tb_data_ram_responder;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        ce  [2];
    logic        we  [2];
    logic [3:0]  sel [2];
    logic [31:0] addr[2];
    logic [31:0] wdat[2];
    logic [31:0] rdata[2];
    logic        ack [2];
    logic        err [2];
    logic        stall[2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ws [2] = '{2, 0};

    always #5 clk = ~clk;

    data_ram_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut_a (
        .clk(clk), .rst(rst[0]), .ce_i(ce[0]), .we_i(we[0]), .sel_i(sel[0]),
        .addr_i(addr[0]), .wdata_i(wdat[0]), .rdata_o(rdata[0]), .ack_o(ack[0]),
        .err_o(err[0]), .stallreq_o(stall[0])
    );

    data_ram_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut_b (
        .clk(clk), .rst(rst[1]), .ce_i(ce[1]), .we_i(we[1]), .sel_i(sel[1]),
        .addr_i(addr[1]), .wdata_i(wdat[1]), .rdata_o(rdata[1]), .ack_o(ack[1]),
        .err_o(err[1]), .stallreq_o(stall[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a request is accepted when seen idle, and its access lands WS+1 edges later.
    typedef struct {
        bit          valid;
        bit          busy;
        int          age;
        bit          ack;
        bit          err;
        logic [31:0] rdata;
        bit          rknown;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mdl_t;

    mdl_t        m [2];
    logic [31:0] mem_m [int];

    function automatic void mdl_step(int i);
        int          key;
        logic [31:0] w;
        if (rst[i]) begin
            m[i].valid = 1; m[i].busy = 0; m[i].ack = 0; m[i].err = 0;
            m[i].rdata = 32'd0; m[i].rknown = 1;
        end else if (!m[i].valid) begin
            return;
        end else if (m[i].ack) begin
            m[i].ack = 0; m[i].err = 0;
        end else if (!m[i].busy) begin
            if (ce[i]) begin
                m[i].busy = 1; m[i].age = 0;
                m[i].we = we[i]; m[i].sel = sel[i]; m[i].addr = addr[i]; m[i].wdata = wdat[i];
            end
        end else begin
            m[i].age++;
            if (m[i].age == ws[i] + 1) begin
                m[i].busy = 0;
                m[i].ack  = 1;
                key = i * 65536 + int'(m[i].addr[11:2]);
                if (m[i].addr[31:12] != 20'd0) begin
                    m[i].err = 1; m[i].rdata = 32'd0; m[i].rknown = 1;
                end else if (m[i].we) begin
                    if (m[i].sel != 4'd0) begin
                        w = mem_m.exists(key) ? mem_m[key] : 32'd0;
                        for (int b = 0; b < 4; b++)
                            if (m[i].sel[b]) w[8*b +: 8] = m[i].wdata[8*b +: 8];
                        mem_m[key] = w;
                    end
                end else begin
                    m[i].rknown = mem_m.exists(key);
                    if (m[i].rknown) m[i].rdata = mem_m[key];
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        mdl_step(0);
        mdl_step(1);
    end

    always @(negedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            if (m[i].valid) begin
                check($sformatf("stall%0d", i), {31'd0, stall[i]},
                      {31'd0, m[i].busy ? 1'b1 : (m[i].ack ? 1'b0 : ce[i])});
                check($sformatf("ack%0d", i), {31'd0, ack[i]}, {31'd0, m[i].ack});
                check($sformatf("err%0d", i), {31'd0, err[i]}, {31'd0, m[i].err});
                if (m[i].rknown)
                    check($sformatf("rdata%0d", i), rdata[i], m[i].rdata);
            end
        end
    end

    task automatic req(input int i, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er,
                       output int lat);
        int t0;
        bit got = 0;
        @(negedge clk);
        ce[i] = 1; we[i] = w; sel[i] = s; addr[i] = a; wdat[i] = d;
        t0 = cyc;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            if (ack[i]) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout%0d: got no ack expected ack within 40 cycles", i);
        end
        lat = cyc - t0; rd = rdata[i]; er = err[i];
        @(negedge clk);
        ce[i] = 0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acks [3];
    int          n, t0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1; ce[i] = 0; we[i] = 0; sel[i] = 4'd0; addr[i] = 32'd0; wdat[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 0; rst[1] = 0;
        #2;
        check("reset_stall", {31'd0, stall[0]}, 32'd0);
        check("reset_ack",   {31'd0, ack[0]},   32'd0);
        check("reset_rdata", rdata[0], 32'd0);

        // Full word store then load, with latency
        req(0, 1, 4'b1111, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("sw_latency", lat, 4);
        req(0, 0, 4'b0000, 32'h10, 32'h0, rd, er, lat);
        check("lw_latency", lat, 4);
        check("lw_full", rd, 32'hDEADBEEF);

        // Byte and halfword lanes, then an empty store
        req(0, 1, 4'b0100, 32'h11, 32'h5A5A5A5A, rd, er, lat);
        req(0, 0, 4'b1111, 32'h10, 32'h0, rd, er, lat);
        check("lw_after_sb", rd, 32'hDE5ABEEF);
        req(0, 1, 4'b0011, 32'h12, 32'h12341234, rd, er, lat);
        req(0, 0, 4'b1111, 32'h10, 32'h0, rd, er, lat);
        check("lw_after_sh", rd, 32'hDE5A1234);
        req(0, 1, 4'b0000, 32'h10, 32'hFFFFFFFF, rd, er, lat);
        req(0, 0, 4'b1111, 32'h10, 32'h0, rd, er, lat);
        check("lw_after_sel0", rd, 32'hDE5A1234);

        // Out of range
        req(0, 1, 4'b1111, 32'h0, 32'h01020304, rd, er, lat);
        req(0, 0, 4'b1111, 32'h1000, 32'h0, rd, er, lat);
        check("oor_err", {31'd0, er}, 32'd1);
        check("oor_rdata", rd, 32'd0);
        req(0, 1, 4'b1111, 32'h1000, 32'hFFFFFFFF, rd, er, lat);
        check("oor_sw_err", {31'd0, er}, 32'd1);
        req(0, 0, 4'b1111, 32'h0, 32'h0, rd, er, lat);
        check("oor_no_write", rd, 32'h01020304);
        check("in_range_err", {31'd0, er}, 32'd0);

        // Zero wait states, ce held across three loads
        req(1, 1, 4'b1111, 32'h4, 32'hCAFEF00D, rd, er, lat);
        check("ws0_latency", lat, 2);
        @(negedge clk);
        ce[1] = 1; we[1] = 0; sel[1] = 4'b1111; addr[1] = 32'h4;
        t0 = cyc; n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(posedge clk); #1;
            if (ack[1]) begin acks[n] = cyc - t0; n++; end
        end
        @(negedge clk);
        ce[1] = 0;
        check("held_ack_count", n, 3);
        check("held_ack1", acks[0], 2);
        check("held_ack2", acks[1], 5);
        check("held_ack3", acks[2], 8);
        check("held_rdata", rdata[1], 32'hCAFEF00D);
        repeat (3) @(negedge clk);
        check("held_no_extra", {31'd0, stall[1]}, 32'd0);

        // Reset in the second wait cycle of a store
        req(0, 1, 4'b1111, 32'h20, 32'h11112222, rd, er, lat);
        @(negedge clk);
        ce[0] = 1; we[0] = 1; sel[0] = 4'b1111; addr[0] = 32'h20; wdat[0] = 32'h33334444;
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1; ce[0] = 0;
        @(negedge clk);
        rst[0] = 0;
        #2;
        check("rst_stall", {31'd0, stall[0]}, 32'd0);
        check("rst_ack",   {31'd0, ack[0]},   32'd0);
        repeat (4) @(negedge clk);
        check("rst_no_late_ack", {31'd0, ack[0]}, 32'd0);
        req(0, 0, 4'b1111, 32'h20, 32'h0, rd, er, lat);
        check("rst_no_write", rd, 32'h11112222);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
